// File: rtl/mux_scan_ctrl_pkg.sv
// Shared constants and state encoding for the mux scan sequencer.
package mux_scan_ctrl_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } state_e;

endpackage

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// Loadable down-counter that holds at zero; zero_c flags the sample edge.
module dwell_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load has priority; decrement stops at zero so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Drives the 4:1 mux select, dwells per channel, samples mux_out and
// assembles a 4-bit frame; single-shot or continuous scanning.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int unsigned DWELL = 50000,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             mux_out,
  output logic [SEL_W-1:0] sel,
  output logic [NUM_CH-1:0] frame_data,
  output logic             frame_valid,
  output logic             busy
);

  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-2:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] frame_data_q, frame_data_d;
  logic              frame_valid_q, frame_valid_d;
  logic              busy_q, busy_d;
  logic              tmr_load, tmr_dec, tmr_zero;

  dwell_timer #(
    .CNT_W (CNT_W)
  ) u_dwell_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (RELOAD),
    .zero_c   (tmr_zero)
  );

  // Next-state: select only moves on sample edges, so the mux sees a stable
  // select for a full dwell period.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    shadow_d      = shadow_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    busy_d        = busy_q;
    tmr_load      = 1'b0;
    tmr_dec       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_DWELL;
          sel_d    = '0;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
        end
      end
      ST_DWELL: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (sel_q != LAST_SEL) begin
          shadow_d[sel_q] = mux_out;
          sel_d           = sel_q + SEL_W'(1);
          tmr_load        = 1'b1;
        end else begin
          // Last channel goes straight into the frame word, bypassing the shadow.
          frame_data_d  = {mux_out, shadow_q};
          frame_valid_d = 1'b1;
          sel_d         = '0;
          if (cont) begin
            tmr_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      shadow_q      <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      shadow_q      <= shadow_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign sel         = sel_q;
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench: two sequencers (dwell 3 and dwell 1) each feeding a 4:1 mux model.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Dwell-3 instance
  logic       start, cont, mux_out;
  logic [3:0] data_in;
  logic [1:0] sel;
  logic [3:0] frame_data;
  logic       frame_valid, busy;

  // Dwell-1 instance
  logic       d1_start, d1_cont, d1_mux_out;
  logic [3:0] d1_data_in;
  logic [1:0] d1_sel;
  logic [3:0] d1_frame_data;
  logic       d1_frame_valid, d1_busy;

  assign mux_out    = data_in[sel];
  assign d1_mux_out = d1_data_in[d1_sel];

  mux_scan_ctrl #(.DWELL(3), .CNT_W(16)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cont        (cont),
    .mux_out     (mux_out),
    .sel         (sel),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .busy        (busy)
  );

  mux_scan_ctrl #(.DWELL(1), .CNT_W(16)) u_dut_d1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (d1_start),
    .cont        (d1_cont),
    .mux_out     (d1_mux_out),
    .sel         (d1_sel),
    .frame_data  (d1_frame_data),
    .frame_valid (d1_frame_valid),
    .busy        (d1_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Watch n cycles of the dwell-3 instance; report pulses and busy cycles seen.
  task automatic quiet_window(input string tag, input int n);
    int pulses;
    int busy_cyc;
    pulses   = 0;
    busy_cyc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (frame_valid) pulses++;
      if (busy) busy_cyc++;
    end
    check({tag, "_pulses"}, pulses, 0);
    check({tag, "_busy"}, busy_cyc, 0);
  endtask

  initial begin
    int cyc;
    int p1;
    int p2;
    bit got;

    rst_n      = 1'b0;
    start      = 1'b0;
    cont       = 1'b0;
    data_in    = 4'b0000;
    d1_start   = 1'b0;
    d1_cont    = 1'b0;
    d1_data_in = 4'b0000;
    repeat (2) @(negedge clk);
    check("rst_sel", sel, 0);
    check("rst_busy", busy, 0);
    check("rst_fdata", frame_data, 0);
    check("rst_fvalid", frame_valid, 0);
    check("rst_d1_busy", d1_busy, 0);
    rst_n = 1'b1;

    // Single shot with extra start pulses while busy and on the last-sample edge.
    @(negedge clk);
    data_in = 4'b1010;
    cont    = 1'b0;
    start   = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 5) || (cyc == 12);
      if (frame_valid) begin
        got = 1'b1;
      end else if (cyc <= 12) begin
        check("ss_sel", sel, (cyc - 1) / 3);
        check("ss_busy_hi", busy, 1);
      end
    end
    start = 1'b0;
    check("ss_latency", cyc, 13);
    check("ss_fdata", frame_data, 4'b1010);
    check("ss_busy_fall", busy, 0);
    check("ss_sel_end", sel, 0);
    @(negedge clk);
    check("ss_pulse_width", frame_valid, 0);
    check("ss_fdata_hold", frame_data, 4'b1010);
    quiet_window("ss_after", 20);

    // Asynchronous reset mid-dwell clears everything without waiting for a clock.
    @(negedge clk);
    data_in = 4'b1111;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_pre_sel", sel, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_sel", sel, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_fdata", frame_data, 0);
    check("rst_mid_fvalid", frame_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_window("rst_after", 20);

    // Continuous: two frames, cont dropped in the middle of frame 2.
    @(negedge clk);
    data_in = 4'b0110;
    cont    = 1'b1;
    start   = 1'b1;
    cyc = 0;
    p1  = 0;
    p2  = 0;
    while (p2 == 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc <= 24) check("ct_sel", sel, ((cyc - 1) / 3) % 4);
      if (frame_valid) begin
        if (p1 == 0) begin
          p1 = cyc;
          check("ct_fdata1", frame_data, 4'b0110);
          check("ct_busy_mid", busy, 1);
        end else begin
          p2 = cyc;
          check("ct_fdata2", frame_data, 4'b1001);
          check("ct_busy_stop", busy, 0);
        end
      end
      if (cyc == 13) data_in = 4'b1001;
      if (cyc == 19) cont = 1'b0;
    end
    check("ct_pulse1_cyc", p1, 13);
    check("ct_pulse2_cyc", p2, 25);
    quiet_window("ct_after", 30);

    // Dwell of 1: select advances every cycle, pulse every 4 cycles.
    @(negedge clk);
    d1_data_in = 4'b1111;
    d1_cont    = 1'b1;
    d1_start   = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      d1_start = 1'b0;
      check("d1_sel", d1_sel, (c - 1) % 4);
      check("d1_fvalid", d1_frame_valid, (c >= 5) && ((c - 1) % 4 == 0));
      if (c == 5) check("d1_fdata", d1_frame_data, 4'b1111);
      if (c == 13) d1_cont = 1'b0;
    end
    @(negedge clk);
    check("d1_last_pulse", d1_frame_valid, 1);
    check("d1_busy_stop", d1_busy, 0);
    @(negedge clk);
    check("d1_no_more", d1_frame_valid, 0);
    check("d1_idle", d1_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
